tdm_demux_1_4: RTL and testbench



---
 rtl/tdm_demux_1_4_if.sv | 27 ++
 rtl/tdm_demux_1_4.sv | 96 +++++++++
 tb/tb_tdm_demux_1_4.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/tdm_demux_1_4_if.sv
// Bundle of the serial-in / parallel-out signals of the 1:4 TDM demultiplexer.
// The master drives the serial stream; the slave is the demultiplexer.
interface tdm_demux_1_4_if #(
  parameter int WIDTH = 1
) ();
  // Stream handshake: a slot is consumed on a rising clk edge only when EN=1;
  // SYNC and IN are don't-care otherwise. There is no back-pressure, and
  // frame_valid / sync_err are single-cycle registered pulses.
  logic               EN;
  logic               SYNC;
  logic [WIDTH-1:0]   IN;
  logic [1:0]         sel;
  logic [4*WIDTH-1:0] OUT;
  logic               frame_valid;
  logic               locked;
  logic               sync_err;

  modport master (
    output EN, SYNC, IN,
    input  sel, OUT, frame_valid, locked, sync_err
  );

  modport slave (
    input  EN, SYNC, IN,
    output sel, OUT, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux_1_4.sv
// 1-to-4 time-division demultiplexer: rebuilds four interleaved channel
// samples from a serial stream and publishes whole frames atomically.
module tdm_demux_1_4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  tdm_demux_1_4_if.slave   bus
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [WIDTH-1:0]   shadow_q [3];
  logic [WIDTH-1:0]   shadow_d [3];
  logic [4*WIDTH-1:0] out_q, out_d;
  logic               fv_q, fv_d;
  logic               err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sel_q   <= 2'd0;
      out_q   <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < 3; i++) shadow_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      for (int i = 0; i < 3; i++) shadow_q[i] <= shadow_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    out_d   = out_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    for (int i = 0; i < 3; i++) shadow_d[i] = shadow_q[i];

    if (bus.EN) begin
      unique case (state_q)
        HUNT: begin
          if (bus.SYNC) begin
            shadow_d[0] = bus.IN;
            sel_d       = 2'd1;
            state_d     = LOCK;
          end
        end
        LOCK: begin
          if (bus.SYNC) begin
            // A sync anywhere but slot 0 drops the partial frame and realigns.
            err_d       = (sel_q != 2'd0);
            shadow_d[0] = bus.IN;
            sel_d       = 2'd1;
          end else begin
            unique case (sel_q)
              2'd0: begin
                err_d   = 1'b1;
                state_d = HUNT;
              end
              2'd1: begin
                shadow_d[1] = bus.IN;
                sel_d       = 2'd2;
              end
              2'd2: begin
                shadow_d[2] = bus.IN;
                sel_d       = 2'd3;
              end
              2'd3: begin
                out_d = {bus.IN, shadow_q[2], shadow_q[1], shadow_q[0]};
                fv_d  = 1'b1;
                sel_d = 2'd0;
              end
              default: ;
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  assign bus.sel         = sel_q;
  assign bus.OUT         = out_q;
  assign bus.frame_valid = fv_q;
  assign bus.locked      = (state_q == LOCK);
  assign bus.sync_err    = err_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Directed bench for tdm_demux_1_4 (WIDTH=1) with hand-computed expectations.
module tb_tdm_demux_1_4;
  localparam int WIDTH = 1;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   fv_count;

  tdm_demux_1_4_if #(.WIDTH(WIDTH)) bus ();

  tdm_demux_1_4 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample #1 after the edge.
  task automatic step(input logic en, input logic sync, input logic in);
    bus.EN   = en;
    bus.SYNC = sync;
    bus.IN   = in;
    @(posedge clk);
    #1;
    if (bus.frame_valid === 1'b1) fv_count++;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] out, input logic [1:0] sel,
                            input logic fv, input logic lck, input logic err);
    check_val({tag, ".OUT"},    32'(bus.OUT),         32'(out));
    check_val({tag, ".sel"},    32'(bus.sel),         32'(sel));
    check_val({tag, ".fv"},     32'(bus.frame_valid), 32'(fv));
    check_val({tag, ".locked"}, 32'(bus.locked),      32'(lck));
    check_val({tag, ".err"},    32'(bus.sync_err),    32'(err));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    fv_count = 0;
    rst      = 1'b1;
    bus.EN   = 1'b0;
    bus.SYNC = 1'b0;
    bus.IN   = '0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b1, 1'b1);
    check_outs("reset", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Basic frame 1,0,1,1
    step(1'b1, 1'b1, 1'b1);
    check_outs("f1.s0", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_outs("f1.s2", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check_outs("f1.done", 4'b1101, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    check_outs("f1.idle", 4'b1101, 2'd0, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames, second one with EN gaps after slot 1
    fv_count = 0;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_outs("b2b.f1", 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    check_outs("b2b.gap", 4'b1111, 2'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_outs("b2b.f2", 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_val("b2b.fv_count", 32'(fv_count), 32'd2);

    // Early sync at sel=2
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check_outs("early.err", 4'b0000, 2'd1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check_outs("early.s1", 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check_outs("early.done", 4'b0101, 2'd0, 1'b1, 1'b1, 1'b0);

    // Missing sync at slot 0
    step(1'b1, 1'b0, 1'b1);
    check_outs("miss.err", 4'b0101, 2'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_outs("miss.hunt", 4'b0101, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check_outs("miss.resume", 4'b0110, 2'd0, 1'b1, 1'b1, 1'b0);

    // Stream with no sync after reset
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    fv_count = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    check_outs("nosync", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    check_val("nosync.fv_count", 32'(fv_count), 32'd0);

    // Reset in the middle of a frame
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_outs("mid.f", 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_outs("mid.pre", 4'b1111, 2'd2, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1);
    check_outs("mid.rst", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    fv_count = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    check_outs("mid.hunt", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("mid.no_fv", 32'(fv_count), 32'd0);
    step(1'b1, 1'b0, 1'b1);
    check_outs("mid.new", 4'b1001, 2'd0, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
